// File: rtl/mt_seeder.sv
// Seeds a Mersenne-Twister generator: streams the N-word initialization
// sequence into the generator, then gates consumer requests once seeded.
module mt_seeder #(
    parameter int unsigned     W = 32,
    parameter int unsigned     N = 624,
    parameter logic [W-1:0]    F = W'(32'h6C078965),
    parameter int unsigned     D = 30
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         seed_valid,
    input  logic [W-1:0] seed,
    output logic         seed_ready,
    input  logic         gen_req,
    output logic         load_value,
    output logic [W-1:0] value,
    output logic         gen_rv,
    output logic         rv_valid,
    output logic         seeded
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  prev_q, prev_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          seeded_q, seeded_d;
    logic          rv_valid_q;
    logic [W-1:0]  mix;
    logic [W-1:0]  init_word;
    logic [W-1:0]  load_word;

    // Knuth-style init step; the product is truncated to W bits (mod 2^W).
    assign mix       = prev_q ^ (prev_q >> D);
    assign init_word = (F * mix) + W'(idx_q);
    assign load_word = (idx_q == '0) ? prev_q : init_word;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            idx_q      <= '0;
            seeded_q   <= 1'b0;
            rv_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            idx_q      <= idx_d;
            seeded_q   <= seeded_d;
            rv_valid_q <= gen_rv;
        end
    end

    // Next state and generator-facing strobes; a seed offer in READY wins over gen_req.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        idx_d      = idx_q;
        seeded_d   = seeded_q;
        seed_ready = 1'b0;
        load_value = 1'b0;
        value      = '0;
        gen_rv     = 1'b0;

        case (state_q)
            IDLE: begin
                seed_ready = 1'b1;
                if (seed_valid) begin
                    prev_d   = seed;
                    idx_d    = '0;
                    state_d  = LOAD;
                    seeded_d = 1'b0;
                end
            end
            LOAD: begin
                load_value = 1'b1;
                value      = load_word;
                prev_d     = load_word;
                if (idx_q == LAST_IDX) begin
                    state_d  = READY;
                    seeded_d = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            READY: begin
                seed_ready = 1'b1;
                if (seed_valid) begin
                    prev_d   = seed;
                    idx_d    = '0;
                    state_d  = LOAD;
                    seeded_d = 1'b0;
                end else begin
                    gen_rv = gen_req;
                end
            end
            default: begin
                state_d  = IDLE;
                seeded_d = 1'b0;
            end
        endcase
    end

    assign seeded   = seeded_q;
    assign rv_valid = rv_valid_q;

endmodule

// File: tb/tb_mt_seeder.sv
// Directed bench for mt_seeder: load sequence, handshakes, reseed and reset abort.
module tb_mt_seeder;

    localparam int unsigned W = 32;
    localparam int unsigned N = 624;
    localparam logic [31:0] F = 32'h6C078965;

    logic         clk;
    logic         n_rst;
    logic         seed_valid;
    logic [W-1:0] seed;
    logic         seed_ready;
    logic         gen_req;
    logic         load_value;
    logic [W-1:0] value;
    logic         gen_rv;
    logic         rv_valid;
    logic         seeded;

    int n_checks;
    int n_fail;
    int cnt;
    logic [31:0] mt_cap [N];

    mt_seeder #(.W(W), .N(N), .F(F), .D(30)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .seed_valid (seed_valid),
        .seed       (seed),
        .seed_ready (seed_ready),
        .gen_req    (gen_req),
        .load_value (load_value),
        .value      (value),
        .gen_rv     (gen_rv),
        .rv_valid   (rv_valid),
        .seeded     (seeded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // First tempered output of MT19937 computed from the captured state words.
    function automatic logic [31:0] first_rv();
        logic [31:0] y;
        logic [31:0] x;
        y = (mt_cap[0] & 32'h80000000) | (mt_cap[1] & 32'h7FFFFFFF);
        x = mt_cap[397] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'h0);
        x = x ^ (x >> 11);
        x = x ^ ((x << 7) & 32'h9D2C5680);
        x = x ^ ((x << 15) & 32'hEFC60000);
        x = x ^ (x >> 18);
        return x;
    endfunction

    // Follows one load burst; optional seed pulse at pulse_at, reset abort at abort_at.
    task automatic load_loop(input string tag, input logic [31:0] s, input int pulse_at,
                             input int abort_at, output int count);
        logic [31:0] exp_v;
        int val_err;
        int side_err;
        exp_v    = s;
        val_err  = 0;
        side_err = 0;
        count    = 0;
        for (int guard = 0; guard < 2000; guard++) begin
            @(negedge clk);
            if (load_value !== 1'b1) break;
            if (value !== exp_v) val_err++;
            if (gen_rv !== 1'b0 || seed_ready !== 1'b0 || seeded !== 1'b0) side_err++;
            if (count < int'(N)) mt_cap[count] = value;
            count++;
            exp_v = (F * (exp_v ^ (exp_v >> 30))) + 32'(count);
            next_cycle();
            seed_valid = (count == pulse_at);
            seed       = 32'hDEADBEEF;
            if (count == abort_at) begin
                n_rst = 1'b0;
                #1;
                check_eq({tag, "_abort_load_value"}, 32'(load_value), 32'd0);
                check_eq({tag, "_abort_seeded"}, 32'(seeded), 32'd0);
                check_eq({tag, "_abort_seed_ready"}, 32'(seed_ready), 32'd1);
                check_eq({tag, "_abort_value"}, value, 32'd0);
                break;
            end
        end
        seed_valid = 1'b0;
        check_eq({tag, "_value_stream_errs"}, 32'(val_err), 32'd0);
        check_eq({tag, "_side_signal_errs"}, 32'(side_err), 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        n_rst      = 1'b0;
        seed_valid = 1'b0;
        seed       = '0;
        gen_req    = 1'b1;

        // Reset state with gen_req already asserted
        #12;
        check_eq("rst_seed_ready", 32'(seed_ready), 32'd1);
        check_eq("rst_load_value", 32'(load_value), 32'd0);
        check_eq("rst_value", value, 32'd0);
        check_eq("rst_gen_rv", 32'(gen_rv), 32'd0);
        check_eq("rst_seeded", 32'(seeded), 32'd0);
        check_eq("rst_rv_valid", 32'(rv_valid), 32'd0);

        next_cycle();
        n_rst = 1'b1;
        next_cycle();
        seed_valid = 1'b1;
        seed       = 32'd5489;
        @(negedge clk);
        check_eq("idle_gen_rv", 32'(gen_rv), 32'd0);
        next_cycle();
        seed_valid = 1'b0;

        // Full load of seed 5489, stray seed pulse at load cycle 100
        load_loop("s5489", 32'd5489, 100, -1, cnt);
        check_eq("s5489_count", 32'(cnt), 32'd624);
        check_eq("s5489_x0", mt_cap[0], 32'h00001571);
        check_eq("s5489_x1", mt_cap[1], 32'h4D98EE96);
        check_eq("ready_seeded", 32'(seeded), 32'd1);
        check_eq("ready_gen_rv_first", 32'(gen_rv), 32'd1);
        check_eq("ready_value_zero", value, 32'd0);
        check_eq("ready_seed_ready", 32'(seed_ready), 32'd1);
        next_cycle();
        gen_req = 1'b0;
        @(negedge clk);
        check_eq("rv_valid_after_gen", 32'(rv_valid), 32'd1);
        check_eq("first_rv_from_state", first_rv(), 32'hD091BB5C);
        next_cycle();
        @(negedge clk);
        check_eq("rv_valid_single", 32'(rv_valid), 32'd0);

        // Request then reseed with simultaneous gen_req
        next_cycle();
        gen_req = 1'b1;
        @(negedge clk);
        check_eq("ready_gen_rv", 32'(gen_rv), 32'd1);
        next_cycle();
        seed_valid = 1'b1;
        seed       = 32'h12345678;
        @(negedge clk);
        check_eq("reseed_gen_rv_blocked", 32'(gen_rv), 32'd0);
        check_eq("reseed_rv_in_flight", 32'(rv_valid), 32'd1);
        check_eq("reseed_seeded_before", 32'(seeded), 32'd1);
        next_cycle();
        seed_valid = 1'b0;
        gen_req    = 1'b0;

        // Reseed load aborted by reset at load cycle 300
        load_loop("reseed", 32'h12345678, -1, 300, cnt);
        check_eq("reseed_abort_count", 32'(cnt), 32'd300);
        check_eq("reseed_x0", mt_cap[0], 32'h12345678);
        next_cycle();
        n_rst = 1'b1;
        next_cycle();
        seed_valid = 1'b1;
        seed       = 32'hFFFFFFFF;
        next_cycle();
        seed_valid = 1'b0;

        // All-ones seed after the abort
        load_loop("ones", 32'hFFFFFFFF, -1, -1, cnt);
        check_eq("ones_count", 32'(cnt), 32'd624);
        check_eq("ones_x0", mt_cap[0], 32'hFFFFFFFF);
        check_eq("ones_x1", mt_cap[1], 32'h4FE1DA6D);
        check_eq("ones_seeded", 32'(seeded), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mt_seeder.md
MT_SEEDER -- requirements
Module: mt_seeder

Interface
REQ-001 The block SHALL take parameters (name, default, meaning), one per line:
- W, 32, state word width.
- N, 624, number of state words.
- F, 32'h6C078965, initialization multiplier.
- D, 30, initialization right-shift (W-2).
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock, rising edge.
- n_rst, in, 1, asynchronous active-low reset.
- seed_valid, in, 1, seed offer.
- seed, in, W, seed word.
- seed_ready, out, 1, seed accepted on a cycle where seed_valid&&seed_ready.
- gen_req, in, 1, consumer requests one random word.
- load_value, out, 1, drives generator load_value.
- value, out, W, drives generator value.
- gen_rv, out, 1, drives generator gen_rv.
- rv_valid, out, 1, generator rv holds a new word this cycle.
- seeded, out, 1, generator state fully initialized.
REQ-003 Reset SHALL be asynchronous and active-low on n_rst; all state SHALL be clocked on the rising edge of clk only.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE (unseeded), LOAD (filling state), READY (seeded).
REQ-005 seed_ready SHALL be 1 in IDLE and READY, and 0 in LOAD; seed_valid in LOAD SHALL be ignored.
REQ-006 On seed acceptance: prev<=seed, idx<=0, state<=LOAD, seeded<=0.
REQ-007 In LOAD, load_value SHALL be 1 combinationally.
REQ-008 In LOAD, value SHALL be prev when idx==0, else low W bits of F*(prev^(prev>>D))+idx.
REQ-009 In LOAD, each edge SHALL do prev<=value and idx<=idx+1; idx width SHALL be clog2(N), with no wrap beyond N-1.
REQ-010 Exactly N load cycles SHALL occur. On the edge with idx==N-1, state<=READY and seeded<=1.
REQ-011 Load order SHALL be x[0] first and x[N-1] last, so that x[0] reaches generator index 0.
REQ-012 Outside LOAD, load_value SHALL be 0 and value SHALL be 0.
REQ-013 gen_rv SHALL be gen_req && state==READY && !(seed_valid); gen_req in IDLE or LOAD SHALL be dropped, not queued.
REQ-014 A simultaneous seed_valid and gen_req in READY SHALL give the reseed priority: gen_rv=0, and LOAD starts on the next cycle.
REQ-015 rv_valid SHALL be gen_rv registered one cycle, matching the generator's registered rv.
REQ-016 load_value and gen_rv SHALL never be 1 in the same cycle.
REQ-017 Reseed from READY SHALL deassert seeded on the acceptance edge; an rv_valid already in flight SHALL still assert for its cycle.
REQ-018 Arithmetic SHALL be modulo 2^W; the multiply SHALL be single-cycle combinational, with only the low W bits kept.

Reset
REQ-019 Reset values SHALL be: state=IDLE, prev=0, idx=0, seeded=0, rv_valid=0; hence seed_ready=1, load_value=0, value=0, gen_rv=0.
REQ-020 Reset asserted mid-LOAD SHALL abort to IDLE immediately, leaving no partial seeded indication; the generator shares n_rst.
REQ-021 After reset release, the first seed SHALL be accepted the first cycle seed_valid=1.

Verification
REQ-022 Seed 32'd5489 accepted -> load cycle 0 value=0x00001571, cycle 1 value=0x4D98EE96; load_value high for exactly 624 consecutive cycles; seeded=1 on the next cycle.
REQ-023 With generator attached, seed 5489 then a single gen_req -> rv=0xD091BB5C (3499211612) with rv_valid=1 one cycle after gen_rv.
REQ-024 gen_req held high from reset through LOAD -> gen_rv=0 throughout; gen_rv=1 on the first READY cycle.
REQ-025 seed_valid pulsed at LOAD cycle 100 -> ignored, seed_ready=0, load count still 624; in READY, seed_valid with gen_req -> gen_rv=0 and LOAD restarts with value=new seed.
REQ-026 n_rst asserted at LOAD cycle 300 -> state IDLE, load_value=0, seeded=0 asynchronously; a reseed then yields a full 624-cycle load.
REQ-027 Seed 0xFFFFFFFF -> cycle 1 value equals (F*(0xFFFFFFFF^0x3)+1) mod 2^32, with no overflow artifacts.
